// File: rtl/dr_byte_writer.sv
`default_nettype none
// ============================================================================
//  Module   : dr_byte_writer
//  Purpose  : Byte-serial memory writer for store instructions. Accepts a
//             1-, 2- or 4-byte value plus a base address in one cycle, then
//             drives an 8-bit memory port one byte per clock at consecutive
//             (wrapping) addresses, followed by a one-cycle Done pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i        in   1       system clock, rising edge
//    rst_ni       in   1       asynchronous active-low reset
//    start_i      in   1       request strobe, sampled only in IDLE
//    size_i       in   2       00=1 byte, 01=2 bytes, 1x=4 bytes
//    data_i       in   32      store value, low 8*N bits used
//    addr_i       in   ADDR_W  base byte address
//    mem_addr_o   out  ADDR_W  byte address of current write
//    mem_data_o   out  8       byte of current write
//    mem_wr_en_o  out  1       write strobe
//    busy_o       out  1       high during the write cycles
//    done_o       out  1       one-cycle pulse after the last byte
// ============================================================================
module dr_byte_writer #(
   parameter int ADDR_W     = 16,
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [1:0]        size_i,
   input  logic [31:0]       data_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_data_o,
   output logic              mem_wr_en_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WRITE  = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t              state_q;
   logic [31:0]         data_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [1:0]          last_q;      // latched byte count minus one (0, 1 or 3)
   logic [1:0]          idx_q;       // byte index k currently on the port
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [7:0]          mem_data_q;
   logic                mem_wr_en_q;
   logic                busy_q;
   logic                done_q;

   logic [1:0]          last_in_d;
   logic [1:0]          idx_d;
   logic [7:0]          first_byte_d;
   logic [7:0]          next_byte_d;
   logic [ADDR_W-1:0]   next_addr_d;

   // Byte k of an N-byte value. Big-endian walks from the top selected byte
   // down (index last-k); little-endian walks up from byte 0.
   function automatic logic [7:0] pick_byte(input logic [31:0] d,
                                            input logic [1:0]  last,
                                            input logic [1:0]  k);
      logic [1:0] sel;
      sel = BIG_ENDIAN ? (last - k) : k;
      case (sel)
         2'd0:    return d[7:0];
         2'd1:    return d[15:8];
         2'd2:    return d[23:16];
         default: return d[31:24];
      endcase
   endfunction

   always_comb begin
      case (size_i)
         2'b00:   last_in_d = 2'd0;
         2'b01:   last_in_d = 2'd1;
         default: last_in_d = 2'd3;   // 10 and 11 both mean four bytes
      endcase
      idx_d        = idx_q + 2'd1;
      first_byte_d = pick_byte(data_i, last_in_d, 2'd0);
      next_byte_d  = pick_byte(data_q, last_q, idx_d);
      // Address arithmetic is ADDR_W wide, so it wraps naturally.
      next_addr_d  = addr_q + ADDR_W'(idx_d);
   end

   // Single FSM; every output is a register loaded one edge ahead, so there
   // is no combinational path from inputs to outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         data_q      <= '0;
         addr_q      <= '0;
         last_q      <= '0;
         idx_q       <= '0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_wr_en_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  state_q     <= S_WRITE;
                  data_q      <= data_i;
                  addr_q      <= addr_i;
                  last_q      <= last_in_d;
                  idx_q       <= 2'd0;
                  // Byte 0 is presented straight from the inputs so that it
                  // appears in the cycle right after the accept edge.
                  mem_addr_q  <= addr_i;
                  mem_data_q  <= first_byte_d;
                  mem_wr_en_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            S_WRITE: begin
               if (idx_q == last_q) begin
                  // Address/data hold their last values; only the strobe drops.
                  state_q     <= S_FINISH;
                  mem_wr_en_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end else begin
                  idx_q      <= idx_d;
                  mem_addr_q <= next_addr_d;
                  mem_data_q <= next_byte_d;
               end
            end
            S_FINISH: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q     <= S_IDLE;
               mem_wr_en_q <= 1'b0;
               busy_q      <= 1'b0;
               done_q      <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr_o  = mem_addr_q;
   assign mem_data_o  = mem_data_q;
   assign mem_wr_en_o = mem_wr_en_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dr_byte_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dr_byte_writer
//  Purpose  : Directed self-checking bench for dr_byte_writer. A big-endian
//             and a little-endian instance share the same stimulus; each
//             scenario task checks the instance its expectations apply to.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dr_byte_writer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  size;
   logic [31:0] data;
   logic [15:0] addr;

   logic [15:0] be_addr, le_addr;
   logic [7:0]  be_data, le_data;
   logic        be_wr, le_wr;
   logic        be_busy, le_busy;
   logic        be_done, le_done;

   int n_tests = 0;
   int n_fail  = 0;

   // Commit counters: a write commits on any rising edge with the strobe high.
   int be_wr_cnt   = 0;
   int be_done_cnt = 0;

   dr_byte_writer #(.ADDR_W(16), .BIG_ENDIAN(1'b1)) dut_be (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .size_i      (size),
      .data_i      (data),
      .addr_i      (addr),
      .mem_addr_o  (be_addr),
      .mem_data_o  (be_data),
      .mem_wr_en_o (be_wr),
      .busy_o      (be_busy),
      .done_o      (be_done)
   );

   dr_byte_writer #(.ADDR_W(16), .BIG_ENDIAN(1'b0)) dut_le (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .size_i      (size),
      .data_i      (data),
      .addr_i      (addr),
      .mem_addr_o  (le_addr),
      .mem_data_o  (le_data),
      .mem_wr_en_o (le_wr),
      .busy_o      (le_busy),
      .done_o      (le_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (be_wr)   be_wr_cnt   <= be_wr_cnt + 1;
      if (be_done) be_done_cnt <= be_done_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request: accept edge happens inside, byte 0 is then visible.
   task automatic launch(input logic [1:0] s, input logic [31:0] d, input logic [15:0] a);
      size  = s;
      data  = d;
      addr  = a;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      size  = 2'b00;
      data  = '0;
      addr  = '0;
      #3;
      n_tests++;
      if ({be_addr, be_data, be_wr, be_busy, be_done} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_be: got addr=%h data=%h wr=%b busy=%b done=%b, want all 0",
                  be_addr, be_data, be_wr, be_busy, be_done);
      end
      n_tests++;
      if ({le_addr, le_data, le_wr, le_busy, le_done} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_le: got addr=%h data=%h wr=%b busy=%b done=%b, want all 0",
                  le_addr, le_data, le_wr, le_busy, le_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // Start low keeps the block idle.
      tick(); tick();
      n_tests++;
      if (be_wr !== 1'b0 || be_busy !== 1'b0 || be_done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_hold: got wr=%b busy=%b done=%b, want 0 0 0", be_wr, be_busy, be_done);
      end
   endtask

   task automatic test_be_word();
      logic [15:0] ea [4];
      logic [7:0]  ed [4];
      int          w0, d0;
      ea = '{16'h0040, 16'h0041, 16'h0042, 16'h0043};
      ed = '{8'h12, 8'h34, 8'h56, 8'h78};
      w0 = be_wr_cnt;
      d0 = be_done_cnt;
      launch(2'b10, 32'h12345678, 16'h0040);
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (be_wr !== 1'b1 || be_busy !== 1'b1 || be_done !== 1'b0 ||
             be_addr !== ea[k] || be_data !== ed[k]) begin
            n_fail++;
            $display("FAIL be_word_byte%0d: got wr=%b busy=%b done=%b (%h,%h), want 1 1 0 (%h,%h)",
                     k, be_wr, be_busy, be_done, be_addr, be_data, ea[k], ed[k]);
         end
         tick();
      end
      n_tests++;
      if (be_done !== 1'b1 || be_busy !== 1'b0 || be_wr !== 1'b0 ||
          be_addr !== 16'h0043 || be_data !== 8'h78) begin
         n_fail++;
         $display("FAIL be_word_done: got done=%b busy=%b wr=%b (%h,%h), want 1 0 0 (0043,78)",
                  be_done, be_busy, be_wr, be_addr, be_data);
      end
      tick();
      n_tests++;
      if (be_done !== 1'b0 || be_busy !== 1'b0 || be_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL be_word_idle: got done=%b busy=%b wr=%b, want 0 0 0", be_done, be_busy, be_wr);
      end
      n_tests++;
      if (be_wr_cnt - w0 !== 4 || be_done_cnt - d0 !== 1) begin
         n_fail++;
         $display("FAIL be_word_counts: got writes=%0d dones=%0d, want 4 1",
                  be_wr_cnt - w0, be_done_cnt - d0);
      end
   endtask

   task automatic test_le_half();
      launch(2'b01, 32'hAABBCCDD, 16'h0010);
      n_tests++;
      if (le_wr !== 1'b1 || le_addr !== 16'h0010 || le_data !== 8'hDD) begin
         n_fail++;
         $display("FAIL le_half_b0: got wr=%b (%h,%h), want 1 (0010,dd)", le_wr, le_addr, le_data);
      end
      tick();
      n_tests++;
      if (le_wr !== 1'b1 || le_addr !== 16'h0011 || le_data !== 8'hCC) begin
         n_fail++;
         $display("FAIL le_half_b1: got wr=%b (%h,%h), want 1 (0011,cc)", le_wr, le_addr, le_data);
      end
      tick();
      n_tests++;
      if (le_done !== 1'b1 || le_wr !== 1'b0 || le_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL le_half_done: got done=%b wr=%b busy=%b, want 1 0 0", le_done, le_wr, le_busy);
      end
      tick();
   endtask

   task automatic test_single_byte();
      int w0;
      w0 = be_wr_cnt;
      launch(2'b00, 32'h00000025, 16'h00FF);
      n_tests++;
      if (be_wr !== 1'b1 || be_busy !== 1'b1 || be_addr !== 16'h00FF || be_data !== 8'h25) begin
         n_fail++;
         $display("FAIL byte1_write: got wr=%b busy=%b (%h,%h), want 1 1 (00ff,25)",
                  be_wr, be_busy, be_addr, be_data);
      end
      tick();
      n_tests++;
      if (be_done !== 1'b1 || be_wr !== 1'b0 || be_wr_cnt - w0 !== 1) begin
         n_fail++;
         $display("FAIL byte1_done: got done=%b wr=%b writes=%0d, want 1 0 1",
                  be_done, be_wr, be_wr_cnt - w0);
      end
      tick();
   endtask

   task automatic test_addr_wrap();
      logic [15:0] ea [4];
      logic [7:0]  ed [4];
      ea = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      ed = '{8'h01, 8'h02, 8'h03, 8'h04};
      launch(2'b10, 32'h01020304, 16'hFFFE);
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (be_wr !== 1'b1 || be_addr !== ea[k] || be_data !== ed[k]) begin
            n_fail++;
            $display("FAIL wrap_byte%0d: got wr=%b (%h,%h), want 1 (%h,%h)",
                     k, be_wr, be_addr, be_data, ea[k], ed[k]);
         end
         tick();
      end
      n_tests++;
      if (be_done !== 1'b1 || be_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_done: got done=%b busy=%b, want 1 0", be_done, be_busy);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] ed [4];
      ed = '{8'h12, 8'h34, 8'h56, 8'h78};
      launch(2'b10, 32'h12345678, 16'h0300);
      // New request (and changed size/addr/data) held through write and finish.
      start = 1'b1;
      data  = 32'hFFFFFFFF;
      size  = 2'b00;
      addr  = 16'h0100;
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (be_wr !== 1'b1 || be_addr !== 16'h0300 + 16'(k) || be_data !== ed[k]) begin
            n_fail++;
            $display("FAIL b2b_byte%0d: got wr=%b (%h,%h), want 1 (%h,%h)",
                     k, be_wr, be_addr, be_data, 16'h0300 + 16'(k), ed[k]);
         end
         tick();
      end
      n_tests++;
      if (be_done !== 1'b1 || be_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done: got done=%b wr=%b, want 1 0", be_done, be_wr);
      end
      tick();
      // Idle cycle after Done: the Start seen during FINISH was not taken.
      n_tests++;
      if (be_wr !== 1'b0 || be_done !== 1'b0 || be_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle: got wr=%b done=%b busy=%b, want 0 0 0", be_wr, be_done, be_busy);
      end
      tick();
      start = 1'b0;
      n_tests++;
      if (be_wr !== 1'b1 || be_addr !== 16'h0100 || be_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL b2b_accept: got wr=%b (%h,%h), want 1 (0100,ff)", be_wr, be_addr, be_data);
      end
      tick();
      tick();
   endtask

   task automatic test_reset_abort();
      int w0, d0;
      w0 = be_wr_cnt;
      d0 = be_done_cnt;
      launch(2'b10, 32'h12345678, 16'h0200);
      tick();          // byte 0 committed
      tick();          // byte 1 committed, byte 2 now on the port
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({be_addr, be_data, be_wr, be_busy, be_done} !== 27'd0) begin
         n_fail++;
         $display("FAIL abort_outputs: got addr=%h data=%h wr=%b busy=%b done=%b, want all 0",
                  be_addr, be_data, be_wr, be_busy, be_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick(); tick();
      n_tests++;
      if (be_wr_cnt - w0 !== 2 || be_done_cnt - d0 !== 0 || be_wr !== 1'b0 || be_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_counts: got writes=%0d dones=%0d wr=%b busy=%b, want 2 0 0 0",
                  be_wr_cnt - w0, be_done_cnt - d0, be_wr, be_busy);
      end
   endtask

   initial begin
      test_reset();
      test_be_word();
      test_le_half();
      test_single_byte();
      test_addr_wrap();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dr_byte_writer.md
Name: dr_byte_writer

Overview:
Byte-serial memory writer, the write-side counterpart of the byte-loaded 32-bit data register. It accepts a 1-, 2- or 4-byte value and a start address in one cycle, then drives the byte-wide memory one byte per clock at consecutive addresses. It sits between the register file/ALU result path and the 8-bit data memory port, and is used for store instructions.

Parameters:
ADDR_W, 16, memory address width; addresses wrap modulo 2^ADDR_W.
BIG_ENDIAN, 1, 1 = most significant selected byte written first, at the base address; 0 = least significant byte first.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  asynchronous, active-low reset.
Start  input  1  request strobe; sampled only in IDLE.
Size  input  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = 4 bytes (alias).
Data  input  32  value to store; bytes taken from Data[8*N-1:0] for an N-byte store.
Addr  input  ADDR_W  base byte address.
MemAddr  output  ADDR_W  byte address for the current write.
MemData  output  8  byte for the current write.
MemWrEn  output  1  write strobe; memory commits MemData at MemAddr on the rising edge where it is 1.
Busy  output  1  high from the accept edge through the edge ending the last byte.
Done  output  1  one-cycle pulse in the cycle after the last byte.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; MemAddr=0, MemData=0, MemWrEn=0, Busy=0, Done=0; latched data, address and count cleared. Reset asserted mid-transfer aborts the transfer immediately. Remaining bytes are not written, and Done does not fire.
- States: IDLE, WRITE, FINISH.
- IDLE: MemWrEn=0. If Start=1 at a rising edge:
  - latch Data, Addr and N (1/2/4 from Size);
  - load byte index k=0;
  - go to WRITE.
  - Start=0 keeps the block in IDLE.
- WRITE: outputs are registered. In the cycle after the accept edge:
  - MemWrEn=1, MemAddr=latched Addr+k (mod 2^ADDR_W), Busy=1;
  - MemData = byte k of the selected N bytes. With BIG_ENDIAN=1, k=0 is Data[8N-1:8N-8]. With BIG_ENDIAN=0, k=0 is Data[7:0].
  - Each edge increments k. After k=N-1 is presented for one cycle, the next edge goes to FINISH.
- FINISH: one cycle; MemWrEn=0, Busy=0, Done=1. The next edge returns to IDLE with Done=0.
- Latency: N write cycles plus one Done cycle. Start edge to Done high takes N+1 edges. Back-to-back requests are therefore at least N+2 cycles apart.
- Start while Busy or in FINISH: ignored, with no queuing. Data, Addr and Size changing during a transfer have no effect (latched values are used).
- Address wrap: Addr=0xFFFF, N=4 writes 0xFFFF, 0x0000, 0x0001, 0x0002. Busy and Done are unaffected.
- MemAddr and MemData hold their last values when MemWrEn=0. The memory must qualify on MemWrEn only.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset=0 pulse during WRITE of a 4-byte store, after 2 bytes -> outputs are 0 immediately, state=IDLE, exactly 2 MemWrEn cycles observed, no Done.
2. BIG_ENDIAN=1, Start with Size=10, Data=32'h12345678, Addr=16'h0040 -> 4 write cycles: (0040,12), (0041,34), (0042,56), (0043,78). Busy is high for those 4 cycles, then Done pulses once, then IDLE.
3. BIG_ENDIAN=0, Size=01, Data=32'hAABBCCDD, Addr=16'h0010 -> writes (0010,DD), (0011,CC); bits 31:16 are never emitted; Done on the 3rd cycle after the accept edge.
4. Size=00, Data=32'h00000025, Addr=16'h00FF -> a single write (00FF,25) with MemWrEn high for exactly one cycle, then Done.
5. Size=10, Addr=16'hFFFE, Data=32'h01020304 (BIG_ENDIAN=1) -> writes (FFFE,01), (FFFF,02), (0000,03), (0001,04).
6. Start re-asserted with new Data=32'hFFFFFFFF during WRITE of 32'h12345678 -> the original bytes complete unchanged. The new request is not accepted. A Start asserted in the cycle after Done is accepted normally.
